fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Parametrised PC register plus next-PC selection for the single-issue core.
//  Replaces the separate PC latch and NPC generator.
//  Adds reset vector, stall hold, trap entry/return, misaligned-target trap and a retire counter.
//  Sits between decode/ALU (branch info in) and the instruction memory address port (pc out).
// PARAMETERS
//  XLEN          32            address/data width
//  RESET_VECTOR  32'h0000_0000 pc value while and after reset
//  C_EXT         0             1: 2-byte alignment rule; 0: 4-byte alignment rule
//  CNT_W         32            width of retire counter
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  rst          in   1      asynchronous, active-high reset
//  en           in   1      advance enable; 0 = stall, all state holds
//  alucode      in   6      decoded ALU op; ALU_JALR selects register-indirect jump
//  br_taken     in   1      branch/JAL taken this cycle (target = pc+imm)
//  imm          in   XLEN   sign-extended immediate
//  reg1dat      in   XLEN   rs1 value for JALR
//  trap_req     in   1      external/illegal-instruction trap request
//  trap_cause   in   4      cause code accompanying trap_req
//  mret         in   1      return from trap to epc
//  mtvec        in   XLEN   trap handler base (low 2 bits ignored)
//  pc           out  XLEN   current fetch address (registered)
//  npc          out  XLEN   combinational next pc (value pc takes on next enabled edge)
//  pc_valid     out  1      0 in BOOT state, 1 in RUN
//  epc          out  XLEN   pc of trapping instruction (registered)
//  ecause       out  4      latched cause; 4'd0 = misaligned fetch target
//  trap_taken   out  1      registered 1-cycle pulse after any trap entry
//  instret      out  CNT_W  count of enabled, non-trapping advances
// BEHAVIOUR
//  Reset (async): pc=RESET_VECTOR, epc=0, ecause=0, trap_taken=0, instret=0, state=BOOT.
//  FSM: BOOT -> RUN on the first clk edge after rst falls (no pc change on that edge); RUN holds.
//  BOOT: pc_valid=0, npc=pc, en/trap_req/mret ignored.
//  RUN target selection, priority high->low:
//   1 trap_req:  npc={mtvec[XLEN-1:2],2'b00}; epc<=pc; ecause<=trap_cause.
//   2 misalign:  computed jump target misaligned -> npc=mtvec base; epc<=pc; ecause<=0.
//   3 mret:      npc=epc.
//   4 JALR:      npc=(reg1dat+imm)&~1.
//   5 br_taken:  npc=pc+imm.
//   6 default:   npc=pc+4.
//  Misaligned: target[1] set when C_EXT=0 (JALR bit0 already cleared; branch bit0 set also counts).
//  Misaligned with C_EXT=1: target[0] set (branch only).
//  Sequential pc+4 is never checked.
//  trap_req is honoured even when en=0; all other cases update only when en=1.
//  trap_taken<=1 on the edge that enters a trap (case 1 or 2), else 0.
//  instret increments on enabled edges in cases 3-6 only; wraps modulo 2^CNT_W.
//  All adds are XLEN-bit, wrap silently (pc=FFFF_FFFC +4 -> 0).
//  Simultaneous trap_req and mret: trap wins, epc takes current pc.
//  JALR and br_taken both set: JALR wins.
//  Reset mid-run: immediate async return to RESET_VECTOR/BOOT; pending trap dropped.
// STRUCTURE
//  Shared package/defines: ALU_* codes (incl. ALU_JALR), cause codes, FSM state encodings.
//  One sub-module: npc_select (pure combinational priority mux + misalign check).
//  Top holds FSM, pc/epc/ecause/instret registers.
// TESTING
//  Reset: rst pulse -> pc=RESET_VECTOR, pc_valid=0 one cycle, then pc=0,4,8 with instret=2.
//  Branch/JALR: pc=0x100, br_taken, imm=-8 -> pc=0xF8.
//  JALR: reg1dat=0x203, imm=0 -> pc=0x202 (C_EXT=1), trap to mtvec (C_EXT=0).
//  Stall: en=0 for 3 cycles -> pc, instret constant; trap_req during stall -> pc=mtvec, epc=stalled pc.
//  Trap/mret: trap_req cause 2 at pc=0x40, mtvec=0x83 -> pc=0x80, epc=0x40, ecause=2, trap_taken 1 cycle.
//  Trap/mret, return: mret -> pc=0x40.
//  Wrap/async reset: pc=0xFFFF_FFFC +4 -> 0.
//  Wrap/async reset: rst asserted mid-cycle -> pc=RESET_VECTOR before next edge.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the fetch PC unit.
// ALU op codes, trap cause codes, FSM states and next-pc select tags.
package fetch_pc_unit_pkg;

    localparam logic [5:0] ALU_ADD  = 6'd0;
    localparam logic [5:0] ALU_SUB  = 6'd1;
    localparam logic [5:0] ALU_JAL  = 6'd30;
    localparam logic [5:0] ALU_JALR = 6'd31;

    localparam logic [3:0] CAUSE_MISALIGN = 4'd0;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        SEL_HOLD     = 3'd0,
        SEL_TRAP     = 3'd1,
        SEL_MISALIGN = 3'd2,
        SEL_MRET     = 3'd3,
        SEL_JALR     = 3'd4,
        SEL_BR       = 3'd5,
        SEL_SEQ      = 3'd6
    } sel_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Control/branch inputs and pc/trap status outputs of the fetch PC unit.
// master drives the controls, slave is the unit itself.
interface fetch_pc_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             en;
    logic [5:0]       alucode;
    logic             br_taken;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  reg1dat;
    logic             trap_req;
    logic [3:0]       trap_cause;
    logic             mret;
    logic [XLEN-1:0]  mtvec;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  npc;
    logic             pc_valid;
    logic [XLEN-1:0]  epc;
    logic [3:0]       ecause;
    logic             trap_taken;
    logic [CNT_W-1:0] instret;

    modport master (
        output en, alucode, br_taken, imm, reg1dat,
        output trap_req, trap_cause, mret, mtvec,
        input  pc, npc, pc_valid, epc, ecause,
        input  trap_taken, instret
    );

    modport slave (
        input  en, alucode, br_taken, imm, reg1dat,
        input  trap_req, trap_cause, mret, mtvec,
        output pc, npc, pc_valid, epc, ecause,
        output trap_taken, instret
    );
endinterface

// File: rtl/fetch_pc_unit_npc_select.sv
// Combinational next-pc priority mux with jump-target alignment check.
// Outside RUN the pc is held; o_sel tells the top which case applied.
module fetch_pc_unit_npc_select
    import fetch_pc_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit C_EXT = 1'b0
) (
    input  logic            i_run,
    input  logic            i_trap_req,
    input  logic            i_mret,
    input  logic            i_br_taken,
    input  logic [5:0]      i_alucode,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_epc,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_reg1dat,
    input  logic [XLEN-1:0] i_mtvec,
    output logic [XLEN-1:0] o_npc,
    output sel_t            o_sel
);

    logic            w_is_jalr;
    logic [XLEN-1:0] w_br_tgt;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_jalr_tgt;
    logic [XLEN-1:0] w_base;
    logic            w_misalign;

    assign w_is_jalr  = (i_alucode == ALU_JALR);
    assign w_br_tgt   = i_pc + i_imm;
    assign w_jalr_sum = i_reg1dat + i_imm;
    assign w_jalr_tgt = {w_jalr_sum[XLEN-1:1], 1'b0};
    assign w_base     = {i_mtvec[XLEN-1:2], 2'b00};

    // JALR already has bit0 cleared, so only branches can fail the 2-byte rule
    always_comb begin
        w_misalign = 1'b0;
        if (C_EXT) begin
            w_misalign = !w_is_jalr && i_br_taken && w_br_tgt[0];
        end else if (w_is_jalr) begin
            w_misalign = w_jalr_tgt[1];
        end else if (i_br_taken) begin
            w_misalign = w_br_tgt[1] | w_br_tgt[0];
        end
    end

    always_comb begin
        o_npc = i_pc;
        o_sel = SEL_HOLD;
        if (!i_run) begin
            o_npc = i_pc;
            o_sel = SEL_HOLD;
        end else if (i_trap_req) begin
            o_npc = w_base;
            o_sel = SEL_TRAP;
        end else if (w_misalign) begin
            o_npc = w_base;
            o_sel = SEL_MISALIGN;
        end else if (i_mret) begin
            o_npc = i_epc;
            o_sel = SEL_MRET;
        end else if (w_is_jalr) begin
            o_npc = w_jalr_tgt;
            o_sel = SEL_JALR;
        end else if (i_br_taken) begin
            o_npc = w_br_tgt;
            o_sel = SEL_BR;
        end else begin
            o_npc = i_pc + XLEN'(4);
            o_sel = SEL_SEQ;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register, boot/run FSM, trap state and retire counter.
// Next-pc choice comes from the npc_select sub-module.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter bit              C_EXT        = 1'b0,
    parameter int              CNT_W        = 32
) (
    input  logic          clk,
    input  logic          rst,
    fetch_pc_unit_if.slave bus
);

    state_t            r_state;
    state_t            w_state_nx;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_epc;
    logic [3:0]        r_ecause;
    logic              r_trap_taken;
    logic [CNT_W-1:0]  r_instret;
    logic [XLEN-1:0]   w_npc;
    sel_t              w_sel;
    logic              w_run;

    assign w_run = (r_state == ST_RUN);

    fetch_pc_unit_npc_select #(
        .XLEN  (XLEN),
        .C_EXT (C_EXT)
    ) u_npc_select (
        .i_run      (w_run),
        .i_trap_req (bus.trap_req),
        .i_mret     (bus.mret),
        .i_br_taken (bus.br_taken),
        .i_alucode  (bus.alucode),
        .i_pc       (r_pc),
        .i_epc      (r_epc),
        .i_imm      (bus.imm),
        .i_reg1dat  (bus.reg1dat),
        .i_mtvec    (bus.mtvec),
        .o_npc      (w_npc),
        .o_sel      (w_sel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_BOOT;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (r_state == ST_BOOT) w_state_nx = ST_RUN;
    end

    // External traps bypass the stall; everything else waits for en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_VECTOR;
            r_epc        <= '0;
            r_ecause     <= '0;
            r_trap_taken <= 1'b0;
            r_instret    <= '0;
        end else begin
            r_trap_taken <= 1'b0;
            if (w_sel == SEL_TRAP) begin
                r_pc         <= w_npc;
                r_epc        <= r_pc;
                r_ecause     <= bus.trap_cause;
                r_trap_taken <= 1'b1;
            end else if (bus.en && w_sel != SEL_HOLD) begin
                r_pc <= w_npc;
                if (w_sel == SEL_MISALIGN) begin
                    r_epc        <= r_pc;
                    r_ecause     <= CAUSE_MISALIGN;
                    r_trap_taken <= 1'b1;
                end else begin
                    r_instret <= r_instret + CNT_W'(1);
                end
            end
        end
    end

    assign bus.pc         = r_pc;
    assign bus.npc        = w_npc;
    assign bus.pc_valid   = w_run;
    assign bus.epc        = r_epc;
    assign bus.ecause     = r_ecause;
    assign bus.trap_taken = r_trap_taken;
    assign bus.instret    = r_instret;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: one C_EXT=0 and one C_EXT=1 instance.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_fetch_pc_unit;
    import fetch_pc_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    fetch_pc_unit_if #(.XLEN(32), .CNT_W(32)) b0 ();
    fetch_pc_unit_if #(.XLEN(32), .CNT_W(32)) b1 ();

    fetch_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1'b0), .CNT_W(32))
        dut0 (.clk(clk), .rst(rst), .bus(b0));
    fetch_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1'b1), .CNT_W(32))
        dut1 (.clk(clk), .rst(rst), .bus(b1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b0.en = 1'b1; b0.alucode = ALU_ADD; b0.br_taken = 1'b0;
        b0.imm = '0; b0.reg1dat = '0; b0.trap_req = 1'b0;
        b0.trap_cause = '0; b0.mret = 1'b0; b0.mtvec = '0;
        b1.en = 1'b1; b1.alucode = ALU_ADD; b1.br_taken = 1'b0;
        b1.imm = '0; b1.reg1dat = '0; b1.trap_req = 1'b0;
        b1.trap_cause = '0; b1.mret = 1'b0; b1.mtvec = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic set_pc0(input logic [31:0] a);
        b0.trap_req = 1'b1;
        b0.mtvec = a;
        tick();
        b0.trap_req = 1'b0;
        b0.mtvec = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        n_total++; if (b0.pc !== 32'h0) $display("FAIL rst_pc got %h exp %h", b0.pc, 32'h0); else n_pass++;
        n_total++; if (b0.pc_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", b0.pc_valid); else n_pass++;
        n_total++; if (b0.instret !== 32'h0) $display("FAIL rst_instret got %0d exp 0", b0.instret); else n_pass++;
        n_total++; if (b0.epc !== 32'h0) $display("FAIL rst_epc got %h exp 0", b0.epc); else n_pass++;
        n_total++; if (b0.trap_taken !== 1'b0) $display("FAIL rst_tt got %b exp 0", b0.trap_taken); else n_pass++;
        b0.trap_req = 1'b1;
        b0.mtvec = 32'h80;
        rst = 1'b0;
        #1;
        n_total++; if (b0.pc_valid !== 1'b0) $display("FAIL boot_valid got %b exp 0", b0.pc_valid); else n_pass++;
        n_total++; if (b0.npc !== 32'h0) $display("FAIL boot_npc got %h exp 0", b0.npc); else n_pass++;
        tick();
        idle();
        n_total++; if (b0.pc !== 32'h0) $display("FAIL boot_pc got %h exp 0", b0.pc); else n_pass++;
        n_total++; if (b0.pc_valid !== 1'b1) $display("FAIL run_valid got %b exp 1", b0.pc_valid); else n_pass++;
        n_total++; if (b0.trap_taken !== 1'b0) $display("FAIL boot_tt got %b exp 0", b0.trap_taken); else n_pass++;
        tick();
        n_total++; if (b0.pc !== 32'h4) $display("FAIL seq_pc4 got %h exp 4", b0.pc); else n_pass++;
        tick();
        n_total++; if (b0.pc !== 32'h8) $display("FAIL seq_pc8 got %h exp 8", b0.pc); else n_pass++;
        n_total++; if (b0.instret !== 32'd2) $display("FAIL seq_instret got %0d exp 2", b0.instret); else n_pass++;
        n_total++; if (b0.npc !== 32'hC) $display("FAIL seq_npc got %h exp c", b0.npc); else n_pass++;
    endtask

    task automatic test_branch();
        do_reset();
        set_pc0(32'h100);
        b0.br_taken = 1'b1;
        b0.imm = 32'hFFFF_FFF8;
        #1;
        n_total++; if (b0.npc !== 32'hF8) $display("FAIL br_npc got %h exp f8", b0.npc); else n_pass++;
        tick();
        n_total++; if (b0.pc !== 32'hF8) $display("FAIL br_pc got %h exp f8", b0.pc); else n_pass++;
        n_total++; if (b0.instret !== 32'd1) $display("FAIL br_instret got %0d exp 1", b0.instret); else n_pass++;
        b0.imm = 32'h2;
        b0.mtvec = 32'h300;
        tick();
        n_total++; if (b0.pc !== 32'h300) $display("FAIL bmis_pc got %h exp 300", b0.pc); else n_pass++;
        n_total++; if (b0.epc !== 32'hF8) $display("FAIL bmis_epc got %h exp f8", b0.epc); else n_pass++;
        n_total++; if (b0.ecause !== 4'd0) $display("FAIL bmis_cause got %0d exp 0", b0.ecause); else n_pass++;
        n_total++; if (b0.trap_taken !== 1'b1) $display("FAIL bmis_tt got %b exp 1", b0.trap_taken); else n_pass++;
        n_total++; if (b0.instret !== 32'd1) $display("FAIL bmis_instret got %0d exp 1", b0.instret); else n_pass++;
        b0.alucode = ALU_JALR;
        b0.reg1dat = 32'h400;
        b0.imm = 32'h8;
        tick();
        idle();
        n_total++; if (b0.pc !== 32'h408) $display("FAIL jalr_prio got %h exp 408", b0.pc); else n_pass++;
        n_total++; if (b0.trap_taken !== 1'b0) $display("FAIL jalr_tt got %b exp 0", b0.trap_taken); else n_pass++;
        n_total++; if (b0.instret !== 32'd2) $display("FAIL jalr_instret got %0d exp 2", b0.instret); else n_pass++;
    endtask

    task automatic test_jalr();
        do_reset();
        b0.alucode = ALU_JALR; b0.reg1dat = 32'h203; b0.mtvec = 32'h500;
        b1.alucode = ALU_JALR; b1.reg1dat = 32'h203; b1.mtvec = 32'h600;
        tick();
        idle();
        n_total++; if (b0.pc !== 32'h500) $display("FAIL jalr0_pc got %h exp 500", b0.pc); else n_pass++;
        n_total++; if (b0.trap_taken !== 1'b1) $display("FAIL jalr0_tt got %b exp 1", b0.trap_taken); else n_pass++;
        n_total++; if (b0.ecause !== 4'd0) $display("FAIL jalr0_cause got %0d exp 0", b0.ecause); else n_pass++;
        n_total++; if (b1.pc !== 32'h202) $display("FAIL jalr1_pc got %h exp 202", b1.pc); else n_pass++;
        n_total++; if (b1.trap_taken !== 1'b0) $display("FAIL jalr1_tt got %b exp 0", b1.trap_taken); else n_pass++;
        b1.br_taken = 1'b1; b1.imm = 32'h1; b1.mtvec = 32'h600;
        tick();
        n_total++; if (b1.pc !== 32'h600) $display("FAIL c_bmis_pc got %h exp 600", b1.pc); else n_pass++;
        n_total++; if (b1.epc !== 32'h202) $display("FAIL c_bmis_epc got %h exp 202", b1.epc); else n_pass++;
        n_total++; if (b1.trap_taken !== 1'b1) $display("FAIL c_bmis_tt got %b exp 1", b1.trap_taken); else n_pass++;
        b1.imm = 32'h2;
        tick();
        idle();
        n_total++; if (b1.pc !== 32'h602) $display("FAIL c_br2_pc got %h exp 602", b1.pc); else n_pass++;
        n_total++; if (b1.instret !== 32'd2) $display("FAIL c_instret got %0d exp 2", b1.instret); else n_pass++;
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        tick();
        b0.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (b0.pc !== 32'h8) $display("FAIL stall_pc%0d got %h exp 8", i, b0.pc); else n_pass++;
            n_total++; if (b0.instret !== 32'd2) $display("FAIL stall_ir%0d got %0d exp 2", i, b0.instret); else n_pass++;
        end
        b0.trap_req = 1'b1; b0.trap_cause = 4'd5; b0.mtvec = 32'h200;
        tick();
        idle();
        n_total++; if (b0.pc !== 32'h200) $display("FAIL strap_pc got %h exp 200", b0.pc); else n_pass++;
        n_total++; if (b0.epc !== 32'h8) $display("FAIL strap_epc got %h exp 8", b0.epc); else n_pass++;
        n_total++; if (b0.ecause !== 4'd5) $display("FAIL strap_cause got %0d exp 5", b0.ecause); else n_pass++;
        n_total++; if (b0.instret !== 32'd2) $display("FAIL strap_ir got %0d exp 2", b0.instret); else n_pass++;
    endtask

    task automatic test_trap_mret();
        do_reset();
        set_pc0(32'h40);
        b0.trap_req = 1'b1; b0.trap_cause = 4'd2; b0.mtvec = 32'h83;
        tick();
        idle();
        n_total++; if (b0.pc !== 32'h80) $display("FAIL trap_pc got %h exp 80", b0.pc); else n_pass++;
        n_total++; if (b0.epc !== 32'h40) $display("FAIL trap_epc got %h exp 40", b0.epc); else n_pass++;
        n_total++; if (b0.ecause !== 4'd2) $display("FAIL trap_cause got %0d exp 2", b0.ecause); else n_pass++;
        n_total++; if (b0.trap_taken !== 1'b1) $display("FAIL trap_tt got %b exp 1", b0.trap_taken); else n_pass++;
        tick();
        n_total++; if (b0.trap_taken !== 1'b0) $display("FAIL trap_tt2 got %b exp 0", b0.trap_taken); else n_pass++;
        n_total++; if (b0.pc !== 32'h84) $display("FAIL trap_seq got %h exp 84", b0.pc); else n_pass++;
        b0.mret = 1'b1;
        #1;
        n_total++; if (b0.npc !== 32'h40) $display("FAIL mret_npc got %h exp 40", b0.npc); else n_pass++;
        tick();
        n_total++; if (b0.pc !== 32'h40) $display("FAIL mret_pc got %h exp 40", b0.pc); else n_pass++;
        n_total++; if (b0.instret !== 32'd2) $display("FAIL mret_ir got %0d exp 2", b0.instret); else n_pass++;
        b0.trap_req = 1'b1; b0.trap_cause = 4'd3; b0.mtvec = 32'h100;
        tick();
        idle();
        n_total++; if (b0.pc !== 32'h100) $display("FAIL tm_pc got %h exp 100", b0.pc); else n_pass++;
        n_total++; if (b0.epc !== 32'h40) $display("FAIL tm_epc got %h exp 40", b0.epc); else n_pass++;
        n_total++; if (b0.ecause !== 4'd3) $display("FAIL tm_cause got %0d exp 3", b0.ecause); else n_pass++;
    endtask

    task automatic test_wrap_async();
        do_reset();
        set_pc0(32'hFFFF_FFFC);
        #1;
        n_total++; if (b0.npc !== 32'h0) $display("FAIL wrap_npc got %h exp 0", b0.npc); else n_pass++;
        tick();
        n_total++; if (b0.pc !== 32'h0) $display("FAIL wrap_pc got %h exp 0", b0.pc); else n_pass++;
        tick();
        tick();
        n_total++; if (b0.pc !== 32'h8) $display("FAIL pre_rst_pc got %h exp 8", b0.pc); else n_pass++;
        n_total++; if (b0.instret !== 32'd3) $display("FAIL pre_rst_ir got %0d exp 3", b0.instret); else n_pass++;
        #2;
        b0.trap_req = 1'b1; b0.mtvec = 32'h700;
        rst = 1'b1;
        #1;
        n_total++; if (b0.pc !== 32'h0) $display("FAIL arst_pc got %h exp 0", b0.pc); else n_pass++;
        n_total++; if (b0.pc_valid !== 1'b0) $display("FAIL arst_valid got %b exp 0", b0.pc_valid); else n_pass++;
        n_total++; if (b0.instret !== 32'd0) $display("FAIL arst_ir got %0d exp 0", b0.instret); else n_pass++;
        tick();
        n_total++; if (b0.trap_taken !== 1'b0) $display("FAIL arst_tt got %b exp 0", b0.trap_taken); else n_pass++;
        n_total++; if (b0.pc !== 32'h0) $display("FAIL arst_hold got %h exp 0", b0.pc); else n_pass++;
        idle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_branch();
        test_jalr();
        test_stall();
        test_trap_mret();
        test_wrap_async();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
